// File: rtl/reduce_pkg.sv
// rtl/reduce_pkg.sv - shared types and elaboration-time helpers for the logical reduction pipeline
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_LNOT = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_RAND = 2'b10,
        MODE_RXOR = 2'b11
    } reduce_mode_t;

    function automatic int clog2(input int value);
        int r = 0;
        int v = 1;
        while (v < value) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int reduce_stages(input int width, input int lps);
        int s = (clog2(width) + lps - 1) / lps;
        return (s < 1) ? 1 : s;
    endfunction

    // Node count left after collapsing a level of pairs `levels` times.
    function automatic int nodes_after(input int nodes, input int levels);
        int n = nodes;
        for (int k = 0; k < levels; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic int node_sum(input int nodes, input int levels);
        int total = 0;
        for (int k = 0; k < levels; k++) begin
            total += nodes_after(nodes, k);
        end
        return total;
    endfunction

    function automatic logic reduce_identity(input reduce_mode_t mode);
        return (mode == MODE_RAND);
    endfunction

    // LNOT reduces as OR; the inversion happens only at the last stage.
    function automatic logic reduce_combine(input reduce_mode_t mode, input logic a, input logic b);
        case (mode)
            MODE_RAND: return a & b;
            MODE_RXOR: return a ^ b;
            default:   return a | b;
        endcase
    endfunction

endpackage

// File: rtl/reduce_tree_stage.sv
// rtl/reduce_tree_stage.sv - a few reduction tree levels for one channel plus their stage register
module reduce_tree_stage
    import reduce_pkg::*;
#(
    parameter int IN_NODES = 4,
    parameter int LEVELS   = 1,
    parameter bit FINAL    = 1'b0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    load,
    input  reduce_mode_t                            mode,
    input  logic [IN_NODES-1:0]                     din,
    output logic [nodes_after(IN_NODES, LEVELS)-1:0] dout_q
);

    localparam int OUT_NODES = nodes_after(IN_NODES, LEVELS);
    localparam int TOTAL     = node_sum(IN_NODES, LEVELS + 1);

    // All levels are packed back to back: level k starts at node_sum(IN_NODES, k).
    logic [TOTAL-1:0]     tree;
    logic [OUT_NODES-1:0] dout_d;

    assign tree[IN_NODES-1:0] = din;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N     = nodes_after(IN_NODES, k);
        localparam int OFF_I = node_sum(IN_NODES, k);
        localparam int OFF_O = OFF_I + N;
        for (genvar i = 0; i < (N + 1) / 2; i++) begin : g_node
            if (2 * i + 1 < N) begin : g_pair
                assign tree[OFF_O+i] = reduce_combine(mode, tree[OFF_I+2*i], tree[OFF_I+2*i+1]);
            end else begin : g_pad
                assign tree[OFF_O+i] = reduce_combine(mode, tree[OFF_I+2*i], reduce_identity(mode));
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (load) begin
            dout_d = tree[TOTAL-1 -: OUT_NODES];
            if (FINAL && mode == MODE_LNOT) begin
                dout_d = ~dout_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/reduce_logic_pipe.sv
// rtl/reduce_logic_pipe.sv - pipelined multi-channel NOR/OR/AND/XOR reduction behind valid/ready
module reduce_logic_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH            = 4,
    parameter int CHANNELS         = 2,
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_data,
    output logic [1:0]                out_mode
);

    localparam int TREE_LEVELS = clog2(WIDTH);
    localparam int STAGES      = reduce_stages(WIDTH, LEVELS_PER_STAGE);

    logic               en;
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  valid_d;
    logic [STAGES-1:0]  stage_vin;
    logic [STAGES-1:0]  load;
    reduce_mode_t       mode_q     [STAGES];
    reduce_mode_t       mode_d     [STAGES];
    reduce_mode_t       stage_mode [STAGES];

    // Single global enable: the whole pipeline advances or holds together.
    always_comb begin
        en            = !valid_q[STAGES-1] || out_ready;
        stage_vin[0]  = in_valid;
        stage_mode[0] = reduce_mode_t'(in_mode);
        for (int s = 1; s < STAGES; s++) begin
            stage_vin[s]  = valid_q[s-1];
            stage_mode[s] = mode_q[s-1];
        end
        valid_d = en ? stage_vin : valid_q;
        load    = stage_vin & {STAGES{en}};
        for (int s = 0; s < STAGES; s++) begin
            mode_d[s] = load[s] ? stage_mode[s] : mode_q[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                mode_q[s] <= MODE_LNOT;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
                mode_q[s] <= mode_d[s];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar s = 0; s < STAGES; s++) begin : g_st
            localparam int FIRST = s * LEVELS_PER_STAGE;
            localparam int LVLS  = (TREE_LEVELS - FIRST < LEVELS_PER_STAGE) ? TREE_LEVELS - FIRST
                                                                             : LEVELS_PER_STAGE;
            localparam int IN_N  = nodes_after(WIDTH, FIRST);
            localparam int OUT_N = nodes_after(IN_N, LVLS);

            logic [IN_N-1:0]  din;
            logic [OUT_N-1:0] dq;

            if (s == 0) begin : g_head
                assign din = in_data[c*WIDTH +: WIDTH];
            end else begin : g_body
                assign din = g_ch[c].g_st[s-1].dq;
            end

            reduce_tree_stage #(
                .IN_NODES (IN_N),
                .LEVELS   (LVLS),
                .FINAL    (s == STAGES - 1)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load[s]),
                .mode   (stage_mode[s]),
                .din    (din),
                .dout_q (dq)
            );

            if (s == STAGES - 1) begin : g_tail
                assign out_data[c] = dq[0];
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];

endmodule
